// File: rtl/cache_ctrl_wb.sv
// cache_ctrl_wb
//   Write-back, write-allocate controller for a 256-line direct-mapped data
//   cache holding one 32-bit word per line. It sits between the CPU data port,
//   the cache array and main memory. Dirty victims are written back and missing
//   lines are refilled over a req/ack memory handshake. Hit, miss and
//   write-back statistics are kept in saturating counters.
//
// Ports
//   CLK, Reset                 clock; asynchronous active-high reset
//   cpu_req/we/addr/wdata      CPU access, held stable until cpu_ready
//   cpu_ready, cpu_rdata       access completion and load data
//   c_addr/we/wdata/dirty      cache array address and write port
//   c_hit/v/d/rdata/rep_tag    cache array lookup results at c_addr
//   mem_req/we/addr/wdata      memory request (we=1 write-back, we=0 refill)
//   mem_rdata, mem_ack         refill data and single-cycle completion pulse
//   hit_cnt/miss_cnt/wb_cnt    saturating statistics counters
module cache_ctrl_wb #(
  parameter int TAG_W   = 22,
  parameter int INDEX_W = 8,
  parameter int CNT_W   = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ready,
  output logic [31:0]       cpu_rdata,
  output logic [31:0]       c_addr,
  output logic              c_we,
  output logic [31:0]       c_wdata,
  output logic              c_dirty,
  input  logic              c_hit,
  input  logic              c_v,
  input  logic              c_d,
  input  logic [31:0]       c_rdata,
  input  logic [TAG_W-1:0]  c_rep_tag,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [CNT_W-1:0]  wb_cnt
);

  typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_t;

  state_t      state, next_state;
  logic [31:0] req_addr;
  logic        refilled;
  logic        miss_evt;
  logic        wb_evt;
  logic        refill_evt;

  // State register plus the miss address, refill flag and statistics.
  // The re-compare hit that follows a refill is not a real hit, so the
  // refilled flag suppresses hit_cnt for exactly that one completion.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state    <= COMPARE;
      req_addr <= '0;
      refilled <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      state <= next_state;
      if (miss_evt)
        req_addr <= cpu_addr;
      if (refill_evt)
        refilled <= 1'b1;
      else if (cpu_ready)
        refilled <= 1'b0;
      if (cpu_ready && !refilled && hit_cnt != '1)
        hit_cnt <= hit_cnt + CNT_W'(1);
      if (miss_evt && miss_cnt != '1)
        miss_cnt <= miss_cnt + CNT_W'(1);
      if (wb_evt && wb_cnt != '1)
        wb_cnt <= wb_cnt + CNT_W'(1);
    end
  end

  // Next-state and output decode. Outside COMPARE the array is addressed by
  // the latched req_addr, so a misbehaving CPU cannot redirect the refill.
  always_comb begin
    next_state = state;
    cpu_ready  = 1'b0;
    cpu_rdata  = c_rdata;
    c_addr     = cpu_addr;
    c_we       = 1'b0;
    c_wdata    = cpu_wdata;
    c_dirty    = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = {req_addr[31:2], 2'b00};
    mem_wdata  = '0;
    miss_evt   = 1'b0;
    wb_evt     = 1'b0;
    refill_evt = 1'b0;
    unique case (state)
      COMPARE: begin
        if (cpu_req) begin
          if (c_hit) begin
            cpu_ready = 1'b1;
            if (cpu_we) begin
              c_we    = 1'b1;
              c_dirty = 1'b1;
            end
          end else begin
            miss_evt   = 1'b1;
            next_state = (c_v && c_d) ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        // The victim's address is rebuilt from its resident tag.
        c_addr    = req_addr;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {c_rep_tag, req_addr[INDEX_W+1:2], 2'b00};
        mem_wdata = c_rdata;
        if (mem_ack) begin
          wb_evt     = 1'b1;
          next_state = ALLOCATE;
        end
      end
      ALLOCATE: begin
        c_addr  = req_addr;
        mem_req = 1'b1;
        c_wdata = mem_rdata;
        if (mem_ack) begin
          c_we       = 1'b1;
          refill_evt = 1'b1;
          next_state = COMPARE;
        end
      end
      default: next_state = COMPARE;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl_wb.sv
// tb_cache_ctrl_wb
//   Directed bench for cache_ctrl_wb. A behavioural cache array and a main
//   memory with programmable ack latency surround the controller. Each CPU
//   access is timed in cycles, from the request cycle (counted as 1) up to and
//   including the cpu_ready cycle.
module tb_cache_ctrl_wb;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        cpu_req, cpu_we, cpu_ready;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        c_we, c_dirty, c_hit, c_v, c_d;
  logic [21:0] c_rep_tag;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;

  int compared   = 0;
  int mismatched = 0;

  always #5 CLK = ~CLK;

  cache_ctrl_wb #(.TAG_W(22), .INDEX_W(8), .CNT_W(32)) dut (
    .CLK(CLK), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .c_addr(c_addr), .c_we(c_we), .c_wdata(c_wdata), .c_dirty(c_dirty),
    .c_hit(c_hit), .c_v(c_v), .c_d(c_d), .c_rdata(c_rdata), .c_rep_tag(c_rep_tag),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
  );

  // Cache array model: combinational lookup, write at the clock edge,
  // valid/dirty cleared by the shared reset.
  logic        vArr [256];
  logic        dArr [256];
  logic [21:0] tagArr [256];
  logic [31:0] dataArr [256];

  always_comb begin
    c_v       = vArr[c_addr[9:2]];
    c_d       = dArr[c_addr[9:2]];
    c_rep_tag = tagArr[c_addr[9:2]];
    c_rdata   = dataArr[c_addr[9:2]];
    c_hit     = vArr[c_addr[9:2]] && (tagArr[c_addr[9:2]] == c_addr[31:10]);
  end

  always @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 256; i++) begin
        vArr[i] <= 1'b0;
        dArr[i] <= 1'b0;
      end
    end else if (c_we) begin
      vArr[c_addr[9:2]]    <= 1'b1;
      dArr[c_addr[9:2]]    <= c_dirty;
      tagArr[c_addr[9:2]]  <= c_addr[31:10];
      dataArr[c_addr[9:2]] <= c_wdata;
    end
  end

  // Memory model: ack in the memLatency-th cycle of a request; every
  // completed transaction is logged for later inspection.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } tx_t;

  logic [31:0] mainMem [1024];
  int          memLatency;
  int          reqCycles;
  tx_t         txLog [$];

  assign mem_ack   = mem_req && (reqCycles == memLatency - 1);
  assign mem_rdata = mainMem[mem_addr[11:2]];

  always @(posedge CLK or posedge Reset) begin
    if (Reset)
      reqCycles <= 0;
    else if (mem_req && !mem_ack)
      reqCycles <= reqCycles + 1;
    else
      reqCycles <= 0;
    if (!Reset && mem_ack)
      txLog.push_back('{we: mem_we, addr: mem_addr, wdata: mem_wdata});
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issue one access, wait (bounded) for cpu_ready, let the completing edge
  // pass, then drop the request.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               output int cycles, output logic [31:0] rdata);
    @(negedge CLK);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cycles    = 0;
    rdata     = '0;
    for (int i = 1; i <= 40; i++) begin
      #2;
      if (cpu_ready) begin
        cycles = i;
        rdata  = cpu_rdata;
        break;
      end
      @(negedge CLK);
    end
    if (cycles == 0)
      checkOutput("ready_timeout", 32'd0, 32'd1);
    @(posedge CLK);
    #1;
    cpu_req = 1'b0;
  endtask

  int          lat;
  logic [31:0] rd;

  initial begin
    for (int i = 0; i < 1024; i++)
      mainMem[i] = 32'h0;
    mainMem[32'h40  >> 2] = 32'hDEAD_BEEF;
    mainMem[32'h440 >> 2] = 32'hCAFE_F00D;
    mainMem[32'h80  >> 2] = 32'h0BAD_F00D;
    mainMem[32'h100 >> 2] = 32'h1111_2222;
    memLatency = 3;
    Reset      = 1'b1;
    cpu_req    = 1'b0;
    cpu_we     = 1'b0;
    cpu_addr   = '0;
    cpu_wdata  = '0;
    @(negedge CLK);
    @(negedge CLK);
    #2;
    checkOutput("rst_ready", {31'd0, cpu_ready}, 32'd0);
    checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst_c_we", {31'd0, c_we}, 32'd0);
    checkOutput("rst_hit_cnt", hit_cnt, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    Reset = 1'b0;

    // Clean load miss, refill acked in its third cycle.
    applyStimulus(1'b0, 32'h0000_0040, 32'h0, lat, rd);
    checkOutput("t1_latency", lat, 32'd5);
    checkOutput("t1_rdata", rd, 32'hDEAD_BEEF);
    checkOutput("t1_miss_cnt", miss_cnt, 32'd1);
    checkOutput("t1_hit_cnt", hit_cnt, 32'd0);
    checkOutput("t1_tx_count", txLog.size(), 32'd1);
    if (txLog.size() >= 1) begin
      checkOutput("t1_tx_we", {31'd0, txLog[0].we}, 32'd0);
      checkOutput("t1_tx_addr", txLog[0].addr, 32'h0000_0040);
    end

    // Store hit then load hit, both zero stall.
    applyStimulus(1'b1, 32'h0000_0040, 32'h1234_5678, lat, rd);
    checkOutput("t2_store_latency", lat, 32'd1);
    applyStimulus(1'b0, 32'h0000_0040, 32'h0, lat, rd);
    checkOutput("t2_load_latency", lat, 32'd1);
    checkOutput("t2_rdata", rd, 32'h1234_5678);
    checkOutput("t2_hit_cnt", hit_cnt, 32'd2);
    checkOutput("t2_dirty", {31'd0, dArr[8'h10]}, 32'd1);

    // Conflicting load: dirty victim written back before the refill.
    applyStimulus(1'b0, 32'h0000_0440, 32'h0, lat, rd);
    checkOutput("t3_latency", lat, 32'd8);
    checkOutput("t3_rdata", rd, 32'hCAFE_F00D);
    checkOutput("t3_tx_count", txLog.size(), 32'd3);
    if (txLog.size() >= 3) begin
      checkOutput("t3_wb_we", {31'd0, txLog[1].we}, 32'd1);
      checkOutput("t3_wb_addr", txLog[1].addr, 32'h0000_0040);
      checkOutput("t3_wb_wdata", txLog[1].wdata, 32'h1234_5678);
      checkOutput("t3_rd_we", {31'd0, txLog[2].we}, 32'd0);
      checkOutput("t3_rd_addr", txLog[2].addr, 32'h0000_0440);
    end
    checkOutput("t3_wb_cnt", wb_cnt, 32'd1);
    checkOutput("t3_miss_cnt", miss_cnt, 32'd2);
    checkOutput("t3_hit_cnt", hit_cnt, 32'd2);
    checkOutput("t3_clean", {31'd0, dArr[8'h10]}, 32'd0);

    // Store miss with a same-cycle ack.
    memLatency = 1;
    applyStimulus(1'b1, 32'h0000_0080, 32'hAAAA_5555, lat, rd);
    checkOutput("t4_latency", lat, 32'd3);
    checkOutput("t4_data", dataArr[8'h20], 32'hAAAA_5555);
    checkOutput("t4_dirty", {31'd0, dArr[8'h20]}, 32'd1);
    checkOutput("t4_miss_cnt", miss_cnt, 32'd3);
    checkOutput("t4_hit_cnt", hit_cnt, 32'd2);
    if (txLog.size() >= 4)
      checkOutput("t4_rd_addr", txLog[3].addr, 32'h0000_0080);

    // Reset in the middle of an allocate.
    memLatency = 10;
    @(negedge CLK);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h0000_0100;
    @(negedge CLK);
    #2;
    checkOutput("t5_alloc_req", {31'd0, mem_req}, 32'd1);
    checkOutput("t5_alloc_addr", mem_addr, 32'h0000_0100);
    checkOutput("t5_alloc_we", {31'd0, mem_we}, 32'd0);
    Reset = 1'b1;
    #1;
    checkOutput("t5_rst_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("t5_rst_ready", {31'd0, cpu_ready}, 32'd0);
    checkOutput("t5_rst_c_we", {31'd0, c_we}, 32'd0);
    checkOutput("t5_rst_miss_cnt", miss_cnt, 32'd0);
    checkOutput("t5_rst_wb_cnt", wb_cnt, 32'd0);
    @(negedge CLK);
    cpu_req    = 1'b0;
    Reset      = 1'b0;
    memLatency = 2;
    applyStimulus(1'b0, 32'h0000_0100, 32'h0, lat, rd);
    checkOutput("t5_remiss_latency", lat, 32'd4);
    checkOutput("t5_remiss_rdata", rd, 32'h1111_2222);
    checkOutput("t5_miss_cnt", miss_cnt, 32'd1);

    // Hit counter saturation.
    force dut.hit_cnt = 32'hFFFF_FFFF;
    applyStimulus(1'b0, 32'h0000_0100, 32'h0, lat, rd);
    release dut.hit_cnt;
    #1;
    checkOutput("t6_sat_first", hit_cnt, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 32'h0000_0100, 32'h0, lat, rd);
    checkOutput("t6_sat_latency", lat, 32'd1);
    checkOutput("t6_sat_hold", hit_cnt, 32'hFFFF_FFFF);
    checkOutput("t6_miss_cnt", miss_cnt, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
